settings_cursor_draw: RTL and testbench
=======================================

# settings_cursor_draw

Navigation and highlight-drawing stage of the settings menu. It holds the selected menu item and each item's value. A two-state browse/edit FSM drives it from three push keys. It produces one registered drawing request plus an 8-bit colour for a border box around the selected item, and that pair feeds one priority slot of the settings RGB mux directly downstream. A blink counter advanced by start-of-frame flashes the box while an item is being edited.

## Interface
Parameters:
- ITEM_COUNT, 4: number of menu items (2..8).
- VALUE_MAX, 3: largest value per item; VALUE_W = $clog2(VALUE_MAX+1).
- ITEM_X, 200: left x of every item box.
- ITEM_Y0, 120: top y of item 0.
- ITEM_PITCH, 48: vertical distance between item tops.
- ITEM_W, 240 / ITEM_H, 32: box width / height in pixels.
- BORDER, 3: border thickness in pixels.
- BLINK_FRAMES, 15: frames per blink half-period.
- RGB_SEL, 8'hFC: border colour in browse.
- RGB_EDIT, 8'hE0: border colour in edit.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset; one clock, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame.
- pixelX  in  11  current pixel x.
- pixelY  in  11  current pixel y.
- menu_active  in  1  settings screen shown.
- key_up / key_down / key_enter  in  1 each  key levels, already synchronised to clk.
- draw_request  out  1  pixel lies on the highlight border.
- rgb  out  8  border colour, valid when draw_request=1.
- sel_idx  out  $clog2(ITEM_COUNT)  selected item.
- values  out  ITEM_COUNT×VALUE_W  packed per-item values.
- apply  out  1  one-cycle pulse when an edit is committed.

## Operation
- Each key is rising-edge detected (registered previous level). Only edges act; held keys do nothing more.
- Same-cycle key priority: enter, then up, then down. If up and down rise together without enter, nothing happens.
- FSM BROWSE (reset state):
  - up: sel_idx−1, wrapping 0→ITEM_COUNT−1.
  - down: sel_idx+1, wrapping ITEM_COUNT−1→0.
  - enter: go to EDIT.
- FSM EDIT:
  - up: values[sel_idx]+1, saturating at VALUE_MAX.
  - down: values[sel_idx]−1, saturating at 0.
  - enter: go to BROWSE and pulse apply for one cycle.
- menu_active=0:
  - forces BROWSE and ignores keys; no apply, even if leaving EDIT.
  - clears the blink counter and phase, and forces draw_request=0.
  - values and sel_idx are retained.
- Blink:
  - The frame counter counts startOfFrame pulses, but only in EDIT.
  - When it reaches BLINK_FRAMES−1 it wraps to 0 and toggles the phase.
  - Entering EDIT resets the counter to 0 with phase visible.
  - In BROWSE the phase is always visible.
- Border hit for the selected item i:
  - top = ITEM_Y0 + i·ITEM_PITCH.
  - The pixel must be inside [ITEM_X, ITEM_X+ITEM_W) × [top, top+ITEM_H).
  - It must not be inside the inner rectangle shrunk by BORDER on all four sides.
  - Compare with 12-bit unsigned arithmetic so the sums cannot overflow.
- draw_request = hit & visible phase & menu_active. rgb = RGB_EDIT in EDIT, RGB_SEL otherwise.

## Timing
- Reset values: draw_request=0, rgb=8'h00, sel_idx=0, values all 0, apply=0, FSM=BROWSE, blink counter=0, phase visible, edge registers=0.
- draw_request and rgb are registered: 1 cycle after pixelX/pixelY.
- A key edge is detected in the cycle after the level rises. sel_idx, values, state and apply update on the next edge, so they are visible 2 cycles after the level rises.
- A box move takes effect on the first pixel compared after sel_idx updates; no tearing guard is applied.
- Reset mid-edit returns everything to the reset values immediately, without an apply pulse.

## Structure
- Shared package settings_pkg holds the FSM enum (SET_BROWSE, SET_EDIT) and the default colour constants.
- The settings priority count stays in include/constants.vh.
- One sub-module, key_edge_detect (clk, resetN, level → rise pulse), instantiated three times.
- The box comparator stays inline.

## Test plan
- Reset, then 4 down presses with ITEM_COUNT=4 → sel_idx 1,2,3,0. One up press from 0 → 3.
- Enter, up ×5 → values[sel] 1,2,3,3,3. Enter → apply high exactly 1 cycle, FSM BROWSE.
- sel_idx=1, scan pixel (200,168) → draw_request=1, rgb=FC one cycle later. Pixel (210,178) (interior) → 0. Pixel (199,168) → 0.
- In EDIT, send 30 startOfFrame pulses with BLINK_FRAMES=15 → border visible for frames 0–14, hidden for 15–29, rgb=E0.
- up and down rise in the same cycle → no change. enter and down together → enter only.
- menu_active dropped during EDIT → draw_request 0, BROWSE, no apply, values kept. Assert resetN mid-edit → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/settings_pkg.sv
// Shared types and default colours for the settings menu blocks.
package settings_pkg;

  typedef enum logic {
    SET_BROWSE = 1'b0,
    SET_EDIT   = 1'b1
  } set_state_e;

  localparam logic [7:0] RGB_SEL_DEFAULT  = 8'hFC;
  localparam logic [7:0] RGB_EDIT_DEFAULT = 8'hE0;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for one synchronised key level; the rise pulse is registered.
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic level,
  output logic rise
);

  logic prev_q, prev_d;
  logic rise_q, rise_d;

  // Next previous-level sample and edge pulse.
  always_comb begin
    prev_d = level;
    rise_d = level & ~prev_q;
  end

  // Edge-detect state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/settings_cursor_draw.sv
// Settings menu cursor: item selection, per-item values, browse/edit FSM
// and the blinking highlight border drawn around the selected item.
module settings_cursor_draw
  import settings_pkg::*;
#(
  parameter int unsigned ITEM_COUNT   = 4,
  parameter int unsigned VALUE_MAX    = 3,
  parameter int unsigned ITEM_X       = 200,
  parameter int unsigned ITEM_Y0      = 120,
  parameter int unsigned ITEM_PITCH   = 48,
  parameter int unsigned ITEM_W       = 240,
  parameter int unsigned ITEM_H       = 32,
  parameter int unsigned BORDER       = 3,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter logic [7:0]  RGB_SEL      = RGB_SEL_DEFAULT,
  parameter logic [7:0]  RGB_EDIT     = RGB_EDIT_DEFAULT
) (
  input  logic                                         clk,
  input  logic                                         resetN,
  input  logic                                         startOfFrame,
  input  logic [10:0]                                  pixelX,
  input  logic [10:0]                                  pixelY,
  input  logic                                         menu_active,
  input  logic                                         key_up,
  input  logic                                         key_down,
  input  logic                                         key_enter,
  output logic                                         draw_request,
  output logic [7:0]                                   rgb,
  output logic [$clog2(ITEM_COUNT)-1:0]                sel_idx,
  output logic [ITEM_COUNT*$clog2(VALUE_MAX+1)-1:0]    values,
  output logic                                         apply
);

  localparam int unsigned SEL_W   = $clog2(ITEM_COUNT);
  localparam int unsigned VALUE_W = $clog2(VALUE_MAX + 1);
  localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(ITEM_COUNT - 1);
  localparam logic [VALUE_W-1:0] VAL_TOP  = VALUE_W'(VALUE_MAX);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam logic [11:0] X_OUT0 = 12'(ITEM_X);
  localparam logic [11:0] X_OUT1 = 12'(ITEM_X + ITEM_W);
  localparam logic [11:0] X_IN0  = 12'(ITEM_X + BORDER);
  localparam logic [11:0] X_IN1  = 12'(ITEM_X + ITEM_W - BORDER);

  logic up_r, dn_r, en_r;

  key_edge_detect u_key_up    (.clk(clk), .resetN(resetN), .level(key_up),    .rise(up_r));
  key_edge_detect u_key_down  (.clk(clk), .resetN(resetN), .level(key_down),  .rise(dn_r));
  key_edge_detect u_key_enter (.clk(clk), .resetN(resetN), .level(key_enter), .rise(en_r));

  set_state_e           state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [VALUE_W-1:0]   val_q [ITEM_COUNT];
  logic [VALUE_W-1:0]   val_d [ITEM_COUNT];
  logic                 apply_q, apply_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic                 draw_q, draw_d;
  logic [7:0]           rgb_q, rgb_d;

  logic                 up_only, dn_only;
  logic [11:0]          px, py, top, bot, in_top, in_bot;
  logic                 outer, inner;

  // Key handling, FSM next state and blink counter.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    val_d   = val_q;
    apply_d = 1'b0;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    up_only = up_r & ~dn_r;
    dn_only = dn_r & ~up_r;
    if (!menu_active) begin
      state_d = SET_BROWSE;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else begin
      case (state_q)
        SET_BROWSE: begin
          cnt_d   = '0;
          phase_d = 1'b1;
          if (en_r) begin
            state_d = SET_EDIT;
          end else if (up_only) begin
            sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
          end else if (dn_only) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
          end
        end
        SET_EDIT: begin
          if (en_r) begin
            state_d = SET_BROWSE;
            apply_d = 1'b1;
            cnt_d   = '0;
            phase_d = 1'b1;
          end else begin
            if (up_only && val_q[sel_q] != VAL_TOP) begin
              val_d[sel_q] = val_q[sel_q] + VALUE_W'(1);
            end else if (dn_only && val_q[sel_q] != '0) begin
              val_d[sel_q] = val_q[sel_q] - VALUE_W'(1);
            end
            if (startOfFrame) begin
              if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
        end
        default: state_d = SET_BROWSE;
      endcase
    end
  end

  // Border hit test for the selected item; 12-bit math keeps sums from wrapping.
  always_comb begin
    px     = 12'(pixelX);
    py     = 12'(pixelY);
    top    = 12'(ITEM_Y0) + 12'(sel_q) * 12'(ITEM_PITCH);
    bot    = top + 12'(ITEM_H);
    in_top = top + 12'(BORDER);
    in_bot = top + 12'(ITEM_H - BORDER);
    outer  = (px >= X_OUT0) && (px < X_OUT1) && (py >= top) && (py < bot);
    inner  = (px >= X_IN0) && (px < X_IN1) && (py >= in_top) && (py < in_bot);
    draw_d = outer & ~inner & phase_q & menu_active;
    rgb_d  = (state_q == SET_EDIT) ? RGB_EDIT : RGB_SEL;
  end

  // Pack per-item values onto the output bus.
  always_comb begin
    values = '0;
    for (int unsigned i = 0; i < ITEM_COUNT; i++) begin
      values[i*VALUE_W +: VALUE_W] = val_q[i];
    end
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= SET_BROWSE;
      sel_q   <= '0;
      for (int unsigned i = 0; i < ITEM_COUNT; i++) begin
        val_q[i] <= '0;
      end
      apply_q <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      draw_q  <= 1'b0;
      rgb_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      apply_q <= apply_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      draw_q  <= draw_d;
      rgb_q   <= rgb_d;
    end
  end

  assign draw_request = draw_q;
  assign rgb          = rgb_q;
  assign sel_idx      = sel_q;
  assign apply        = apply_q;

endmodule

// File: tb/tb_settings_cursor_draw.sv
// Directed bench for settings_cursor_draw with hand-computed expectations.
module tb_settings_cursor_draw;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        menu_active = 1'b0;
  logic        key_up = 1'b0;
  logic        key_down = 1'b0;
  logic        key_enter = 1'b0;
  logic        draw_request;
  logic [7:0]  rgb;
  logic [1:0]  sel_idx;
  logic [7:0]  values;
  logic        apply;

  int total = 0;
  int bad   = 0;

  settings_cursor_draw dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .menu_active(menu_active),
    .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
    .draw_request(draw_request), .rgb(rgb), .sel_idx(sel_idx),
    .values(values), .apply(apply)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise the given keys, hold two cycles (result then visible), release.
  task automatic press(input logic u, input logic d, input logic e, input logic exp_apply);
    key_up = u; key_down = d; key_enter = e;
    tick();
    tick();
    check("apply_pulse", apply, exp_apply);
    key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
    tick();
    check("apply_low", apply, 1'b0);
  endtask

  task automatic pix(input int x, input int y, input logic exp_draw, input string tag);
    pixelX = 11'(x); pixelY = 11'(y);
    tick();
    check(tag, draw_request, exp_draw);
  endtask

  initial begin
    logic [1:0] exp_sel [4];
    logic [1:0] exp_val [5];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
    exp_val[0] = 2'd1; exp_val[1] = 2'd2; exp_val[2] = 2'd3; exp_val[3] = 2'd3; exp_val[4] = 2'd3;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_draw", draw_request, 1'b0);
    check("rst_rgb", rgb, 8'h00);
    check("rst_sel", sel_idx, 2'd0);
    check("rst_values", values, 8'h00);
    check("rst_apply", apply, 1'b0);
    resetN = 1'b1;
    menu_active = 1'b1;
    tick();
    check("browse_rgb", rgb, 8'hFC);

    // browse navigation with wrap both ways
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1, 1'b0, 1'b0);
      check("sel_down", sel_idx, exp_sel[i]);
    end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("sel_up_wrap", sel_idx, 2'd3);

    // edit item 3, saturate at VALUE_MAX, commit
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("edit_rgb", rgb, 8'hE0);
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 1'b0, 1'b0);
      check("val_up_sat", values[7:6], exp_val[i]);
    end
    press(1'b0, 1'b0, 1'b1, 1'b1);
    check("browse_after_commit", rgb, 8'hFC);

    // select item 1 (3 -> 0 -> 1), border geometry
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("sel_item1", sel_idx, 2'd1);
    pix(200, 168, 1'b1, "pix_corner");
    check("pix_corner_rgb", rgb, 8'hFC);
    pix(210, 178, 1'b0, "pix_interior");
    pix(199, 168, 1'b0, "pix_left_out");
    pix(439, 168, 1'b1, "pix_right_edge");
    pix(440, 168, 1'b0, "pix_right_out");
    pix(200, 199, 1'b1, "pix_bottom_edge");
    pix(200, 200, 1'b0, "pix_bottom_out");
    pix(202, 171, 1'b1, "pix_border_in");
    pix(203, 171, 1'b0, "pix_inner_corner");
    pix(300, 167, 1'b0, "pix_top_out");

    // blink in edit: visible frames 0..14, hidden 15..29, visible again at 30
    pixelX = 11'd200; pixelY = 11'd168;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("blink_rgb", rgb, 8'hE0);
    check("blink_f0", draw_request, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      check("blink_frame", draw_request, (k % 30) < 15);
    end

    // simultaneous keys in edit
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("val_down_sat0", values, 8'hC0);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    check("updown_edit", values, 8'hC0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("val_item1_up", values, 8'hC4);
    press(1'b0, 1'b1, 1'b1, 1'b1);
    check("enter_down_vals", values, 8'hC4);
    check("enter_down_state", rgb, 8'hFC);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    check("updown_browse", sel_idx, 2'd1);

    // menu dropped during edit
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("edit_again", rgb, 8'hE0);
    menu_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("inactive_apply", apply, 1'b0);
      check("inactive_draw", draw_request, 1'b0);
    end
    check("inactive_browse", rgb, 8'hFC);
    menu_active = 1'b1;
    tick();
    check("reactive_draw", draw_request, 1'b1);
    check("kept_values", values, 8'hC4);
    check("kept_sel", sel_idx, 2'd1);

    // asynchronous reset mid-edit
    press(1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_reset_vals", values, 8'hC8);
    #2 resetN = 1'b0;
    #1;
    check("arst_draw", draw_request, 1'b0);
    check("arst_rgb", rgb, 8'h00);
    check("arst_sel", sel_idx, 2'd0);
    check("arst_values", values, 8'h00);
    check("arst_apply", apply, 1'b0);
    tick();
    resetN = 1'b1;
    tick();
    check("post_reset_browse", rgb, 8'hFC);
    check("post_reset_apply", apply, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
